seq_alu_unit: RTL and testbench
===============================

Name: seq_alu_unit

Overview:
- Multi-cycle execution unit directly downstream of the 8x8 register file.
- Consumes the two register-file read ports (REGOUT1, REGOUT2) and produces an 8-bit result for register-file write-back (IN / WRITE path).
- Executes iterative operations one bit per cycle: multiply (low byte), logical/arithmetic shifts, rotate.
- Uses a START/BUSY/DONE handshake so the control unit can stall the PC while an operation runs.

Parameters:
WIDTH, 8, operand/result width in bits
CNT_W, 4, iteration counter width; must hold the value WIDTH

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  request; sampled only in IDLE or DONE state
OPCODE  input  3  operation select, captured with START
DATA1  input  WIDTH  operand A (from REGOUT1)
DATA2  input  WIDTH  operand B for MUL; shift amount in bits [3:0] for shifts
BUSY  output  1  high while state is RUN
DONE  output  1  one-cycle pulse; RESULT valid
RESULT  output  WIDTH  registered result; held until the next accepted START
ZERO  output  1  registered; equals (RESULT == 0)

Behaviour:
- Reset:
  - RESET high sets state to IDLE immediately, regardless of clock.
  - BUSY=0, DONE=0, RESULT=0, ZERO=1; counter and operand registers cleared.
  - RESET mid-operation aborts the operation and produces no DONE.
- States and transitions:
  - IDLE: START=1 -> capture A, B, OPCODE, k; go to RUN if k>0, else to DONE.
  - RUN: one step per edge, counter decrements; on the step where counter==1 -> DONE.
  - DONE: DONE=1 for exactly this cycle. START=1 here is accepted exactly as in IDLE (back-to-back); otherwise -> IDLE.
- START while BUSY is ignored; operands are not re-sampled.
- Latency: START accepted at edge t0 -> DONE high after edge t0+k (k=0: after edge t0).
- Opcodes and iteration count k:
  - 000 MUL: k=WIDTH.
    - Each step: if B[0], acc += A; A <<= 1; B >>= 1.
    - RESULT = low WIDTH bits of the product; overflow bits are discarded silently.
  - 001 SLL, 010 SRL, 011 SRA:
    - k = min(DATA2[3:0], WIDTH); one-bit shift per step.
    - SRA fills with the original A[WIDTH-1].
    - Amount >= WIDTH gives 0 for SLL/SRL and all sign bits for SRA.
  - 100 ROR: k = DATA2[3:0] mod WIDTH; one-bit right rotate per step.
  - 101-111 illegal: k=0, RESULT=0.
- Shift amount 0 (k=0) -> RESULT=A, DONE after edge t0.
- RESULT and ZERO update only on the edge entering DONE; they are stable in IDLE and RUN.

Optional Feature:
Macro MUL_EARLY_TERM_EN.
- Defined: MUL leaves RUN after the step that leaves B==0. If B==0 at capture, k=0 and RESULT=0 with DONE after edge t0.
- Undefined: MUL always takes exactly WIDTH steps.
- RESULT values are identical in both builds; only latency differs.

Decomposition:
- Package seq_alu_pkg:
  - opcode constants OP_MUL, OP_SLL, OP_SRL, OP_SRA, OP_ROR
  - state encoding ST_IDLE, ST_RUN, ST_DONE
  - default WIDTH
- One sub-module, seq_alu_step: combinational single-step datapath. Inputs are opcode, acc, A, B, sign bit; outputs are the next acc/A/B.
- Top level holds the FSM, counter and result registers.

Test Plan:
- Reset, then MUL: DATA1=13, DATA2=11, START for 1 cycle -> BUSY for 8 cycles, DONE after edge t0+8, RESULT=143 (0x8F), ZERO=0. With MUL_EARLY_TERM_EN -> DONE after edge t0+4.
- MUL overflow: DATA1=20, DATA2=20 -> RESULT=0x90 (400 mod 256).
- Shifts:
  - SRA 0x90 by 3 -> RESULT=0xF2 after 3 steps.
  - SLL 0x81 by 12 -> RESULT=0x00 after 8 steps, ZERO=1.
  - ROR 0x81 by 1 -> RESULT=0xC0.
  - SRL by 0 with DATA1=0x5A -> RESULT=0x5A, DONE after edge t0.
- Handshake:
  - START held high during RUN with changed DATA1/DATA2 -> no effect on result.
  - START=1 in the DONE cycle with SLL 0x01 by 2 -> second operation runs immediately, RESULT=0x04.
- RESET mid-MUL (assert between clock edges, 4 cycles in) -> outputs clear immediately, no DONE, RESULT=0, ZERO=1. Next MUL 3*5 -> RESULT=15.
- Illegal opcode 111 -> RESULT=0, ZERO=1, DONE after edge t0, BUSY never high.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: default operand width,
// opcode constants and FSM state encoding.
package seq_alu_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// START/BUSY/DONE handshake bundle between the control unit / register
// file (master) and the sequential ALU (slave).
interface seq_alu_if #(
  parameter int WIDTH = 8
) ();

  logic             START;
  logic [2:0]       OPCODE;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             ZERO;

  modport master (
    output START, OPCODE, DATA1, DATA2,
    input  BUSY, DONE, RESULT, ZERO
  );

  modport slave (
    input  START, OPCODE, DATA1, DATA2,
    output BUSY, DONE, RESULT, ZERO
  );

endinterface

// File: rtl/seq_alu_step.sv
// Combinational single-iteration datapath: one shift-add multiply step,
// or a one-bit shift/rotate of operand A.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] a_n,
  output logic [WIDTH-1:0] b_n
);

  // one step of the selected operation; unused operands pass through
  always_comb begin
    acc_n = acc;
    a_n   = a;
    b_n   = b;
    case (op)
      OP_MUL: begin
        if (b[0]) acc_n = acc + a;
        a_n = a << 1;
        b_n = b >> 1;
      end
      OP_SLL:  a_n = a << 1;
      OP_SRL:  a_n = a >> 1;
      OP_SRA:  a_n = {sign, a[WIDTH-1:1]};
      OP_ROR:  a_n = {a[0], a[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU behind the register file: MUL (low byte), SLL, SRL,
// SRA and ROR executed one bit per cycle with a START/BUSY/DONE handshake.
// Optional build macro MUL_EARLY_TERM_EN: MUL stops as soon as the
// remaining multiplier is zero (same results, shorter latency).
module seq_alu_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  seq_alu_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] step_acc, step_a, step_b;
  logic [WIDTH-1:0] fin_res;
  logic             early_c;
  int               k_c;

  // Number of single-bit steps an operation needs once captured.
  function automatic int iter_count(input logic [2:0] op, input logic [WIDTH-1:0] b);
    int amt;
    amt = int'(b[3:0]);
    case (op)
`ifdef MUL_EARLY_TERM_EN
      OP_MUL:                 iter_count = (b == '0) ? 0 : WIDTH;
`else
      OP_MUL:                 iter_count = WIDTH;
`endif
      OP_SLL, OP_SRL, OP_SRA: iter_count = (amt >= WIDTH) ? WIDTH : amt;
      OP_ROR:                 iter_count = amt % WIDTH;
      default:                iter_count = 0;
    endcase
  endfunction

  // Result when no step is needed: shifts/rotates by zero return A,
  // a zero multiplier and illegal opcodes return 0.
  function automatic logic [WIDTH-1:0] zero_step_result(input logic [2:0] op,
                                                        input logic [WIDTH-1:0] a);
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: zero_step_result = a;
      default:                        zero_step_result = '0;
    endcase
  endfunction

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .acc   (acc_q),
    .a     (a_q),
    .b     (b_q),
    .sign  (sign_q),
    .acc_n (step_acc),
    .a_n   (step_a),
    .b_n   (step_b)
  );

  assign fin_res = (op_q == OP_MUL) ? step_acc : step_a;

`ifdef MUL_EARLY_TERM_EN
  assign early_c = (op_q == OP_MUL) && (step_b == '0);
`else
  assign early_c = 1'b0;
`endif

  // next-state, operand capture, per-step update and result latch
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    result_d = result_q;
    zero_d   = zero_q;
    k_c      = 0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.START) begin
          op_d   = bus.OPCODE;
          a_d    = bus.DATA1;
          b_d    = bus.DATA2;
          acc_d  = '0;
          sign_d = bus.DATA1[WIDTH-1];
          k_c    = iter_count(bus.OPCODE, bus.DATA2);
          if (k_c == 0) begin
            state_d  = ST_DONE;
            result_d = zero_step_result(bus.OPCODE, bus.DATA1);
            zero_d   = (zero_step_result(bus.OPCODE, bus.DATA1) == '0);
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(k_c);
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        a_d   = step_a;
        b_d   = step_b;
        cnt_d = cnt_q - CNT_W'(1);
        if ((cnt_q == CNT_W'(1)) || early_c) begin
          state_d  = ST_DONE;
          result_d = fin_res;
          zero_d   = (fin_res == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counter, operand and result registers; reset aborts any operation
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.BUSY   = (state_q == ST_RUN);
  assign bus.DONE   = (state_q == ST_DONE);
  assign bus.RESULT = result_q;
  assign bus.ZERO   = zero_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: directed cases with literal
// expectations plus randomized operations against a behavioural model.
module tb_seq_alu_unit;
  import seq_alu_pkg::*;

`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  seq_alu_if #(.WIDTH(8)) bus();

  seq_alu_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int mdl_lat(input logic [2:0] op, input logic [7:0] b);
    int amt;
    amt = int'(b[3:0]);
    case (op)
      3'd0: begin
        if (EARLY) begin
          int n;
          n = 0;
          for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
          return n;
        end
        return 8;
      end
      3'd1, 3'd2, 3'd3: return (amt >= 8) ? 8 : amt;
      3'd4: return amt % 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] mdl_res(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int amt;
    logic [15:0] p;
    amt = int'(b[3:0]);
    case (op)
      3'd0: begin p = 16'(a) * 16'(b); return p[7:0]; end
      3'd1: return (amt >= 8) ? 8'h00 : 8'(a << amt);
      3'd2: return 8'(a >> amt);
      3'd3: return 8'($signed(a) >>> ((amt >= 8) ? 7 : amt));
      3'd4: begin p = {a, a} >> (amt % 8); return p[7:0]; end
      default: return 8'h00;
    endcase
  endfunction

  int         m_rem;
  logic [7:0] m_pend, m_result;
  logic       m_done, m_zero;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem    <= 0;
      m_done   <= 1'b0;
      m_result <= 8'h00;
      m_zero   <= 1'b1;
      m_pend   <= 8'h00;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done   <= 1'b1;
        m_result <= m_pend;
        m_zero   <= (m_pend == 8'h00);
      end else begin
        m_done <= 1'b0;
      end
    end else if (bus.START) begin
      if (mdl_lat(bus.OPCODE, bus.DATA2) == 0) begin
        m_done   <= 1'b1;
        m_result <= mdl_res(bus.OPCODE, bus.DATA1, bus.DATA2);
        m_zero   <= (mdl_res(bus.OPCODE, bus.DATA1, bus.DATA2) == 8'h00);
      end else begin
        m_done <= 1'b0;
        m_rem  <= mdl_lat(bus.OPCODE, bus.DATA2);
        m_pend <= mdl_res(bus.OPCODE, bus.DATA1, bus.DATA2);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    check("cyc_busy", int'(bus.BUSY), int'(m_rem > 0));
    check("cyc_done", int'(bus.DONE), int'(m_done));
    check("cyc_result", int'(bus.RESULT), int'(m_result));
    check("cyc_zero", int'(bus.ZERO), int'(m_zero));
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_res, input int exp_lat,
                       input bit hold, input bit b2b);
    int lat;
    bit busy_seen;
    lat = 0;
    busy_seen = 1'b0;
    if (!b2b) @(negedge clk);
    bus.START  = 1'b1;
    bus.OPCODE = op;
    bus.DATA1  = a;
    bus.DATA2  = b;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.DONE || lat >= 40) break;
      busy_seen  = busy_seen | bus.BUSY;
      bus.START  = hold;
      bus.OPCODE = 3'($urandom);
      bus.DATA1  = 8'($urandom);
      bus.DATA2  = 8'($urandom);
      @(posedge clk);
      lat++;
    end
    bus.START = 1'b0;
    check({nm, "_done"}, int'(bus.DONE), 1);
    check({nm, "_lat"}, lat, exp_lat);
    check({nm, "_res"}, int'(bus.RESULT), int'(exp_res));
    check({nm, "_zero"}, int'(bus.ZERO), int'(exp_res == 8'h00));
    check({nm, "_busy"}, int'(busy_seen), int'(exp_lat > 0));
  endtask

  initial begin
    bus.START  = 1'b0;
    bus.OPCODE = 3'd0;
    bus.DATA1  = 8'h00;
    bus.DATA2  = 8'h00;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_done", int'(bus.DONE), 0);
    check("rst_result", int'(bus.RESULT), 0);
    check("rst_zero", int'(bus.ZERO), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("mul13x11", OP_MUL, 8'd13, 8'd11, 8'h8F, EARLY ? 4 : 8, 1'b1, 1'b0);
    do_op("mul_ovf", OP_MUL, 8'd20, 8'd20, 8'h90, EARLY ? 5 : 8, 1'b0, 1'b0);
    do_op("sra", OP_SRA, 8'h90, 8'd3, 8'hF2, 3, 1'b0, 1'b0);
    do_op("sll12", OP_SLL, 8'h81, 8'd12, 8'h00, 8, 1'b1, 1'b0);
    do_op("ror1", OP_ROR, 8'h81, 8'd1, 8'hC0, 1, 1'b0, 1'b0);
    do_op("srl0", OP_SRL, 8'h5A, 8'd0, 8'h5A, 0, 1'b0, 1'b0);
    do_op("sra_big", OP_SRA, 8'h80, 8'd9, 8'hFF, 8, 1'b0, 1'b0);
    do_op("illegal", 3'b111, 8'hFF, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
    do_op("b2b_first", OP_SRA, 8'h90, 8'd3, 8'hF2, 3, 1'b0, 1'b0);
    do_op("b2b_sll", OP_SLL, 8'h01, 8'd2, 8'h04, 2, 1'b0, 1'b1);

    // reset in the middle of a multiply, between clock edges
    @(negedge clk);
    bus.START  = 1'b1;
    bus.OPCODE = OP_MUL;
    bus.DATA1  = 8'd200;
    bus.DATA2  = 8'd255;
    @(posedge clk);
    @(negedge clk);
    bus.START = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(bus.BUSY), 0);
    check("abort_done", int'(bus.DONE), 0);
    check("abort_result", int'(bus.RESULT), 0);
    check("abort_zero", int'(bus.ZERO), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("abort_no_done", int'(bus.DONE), 0);
    end
    do_op("mul3x5", OP_MUL, 8'd3, 8'd5, 8'd15, EARLY ? 3 : 8, 1'b0, 1'b0);

    // randomized operations against the model
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      bit hold, b2b;
      op   = 3'($urandom_range(0, 7));
      a    = 8'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      b2b  = ($urandom_range(0, 3) == 0);
      do_op("rand", op, a, b, mdl_res(op, a, b), mdl_lat(op, b), hold, b2b);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
